// File: rtl/step_error_if.sv
// Result, target and error streams between the step unit,
// the training-data source and the error consumer.
interface step_error_if;
    logic       train;
    logic       result_valid;
    logic [7:0] result_data;
    logic       result_ready;
    logic       target_valid;
    logic [7:0] target_data;
    logic       target_ready;
    logic        error_valid;
    logic [15:0] error_data;
    logic        error_ready;

    modport slave (
        input  train,
        input  result_valid,
        input  result_data,
        output result_ready,
        input  target_valid,
        input  target_data,
        output target_ready,
        output error_valid,
        output error_data,
        input  error_ready
    );

    modport master (
        output train,
        output result_valid,
        output result_data,
        input  result_ready,
        output target_valid,
        output target_data,
        input  target_ready,
        input  error_valid,
        input  error_data,
        output error_ready
    );
endinterface

// File: rtl/step_error.sv
// Delta-rule error generator: error = (target - result) << SHIFT.
// Define STEP_ERROR_COUNT_EN to build the sample/mismatch counters.
module step_error #(
    parameter int SHIFT   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    step_error_if.slave        bus,
    output logic [COUNT_W-1:0] sample_count,
    output logic [COUNT_W-1:0] mismatch_count
);

    typedef enum logic [1:0] {RES, TGT, ERR} state_t;

    state_t state_q, state_d;
    logic   res_fire, tgt_fire, err_load, err_fire;

    logic [7:0]         res_q, tgt_q;
    logic               err_v_q;
    logic [15:0]        err_q;
    logic signed [8:0]  diff;
    logic signed [15:0] diff_x;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= RES;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        res_fire = 1'b0;
        tgt_fire = 1'b0;
        err_load = 1'b0;
        err_fire = 1'b0;
        unique case (state_q)
            RES: begin
                if (bus.result_valid) begin
                    res_fire = 1'b1;
                    state_d  = bus.train ? TGT : RES;
                end
            end
            TGT: begin
                if (bus.target_valid) begin
                    tgt_fire = 1'b1;
                    state_d  = ERR;
                end
            end
            ERR: begin
                if (!err_v_q) begin
                    err_load = 1'b1;
                end else if (bus.error_ready) begin
                    err_fire = 1'b1;
                    state_d  = RES;
                end
            end
            default: state_d = RES;
        endcase
    end

    assign bus.result_ready = (state_q == RES);
    assign bus.target_ready = (state_q == TGT);
    assign bus.error_valid  = err_v_q;
    assign bus.error_data   = err_q;

    // 9-bit difference cannot overflow 16 bits for SHIFT <= 7
    assign diff   = $signed({1'b0, tgt_q}) - $signed({1'b0, res_q});
    assign diff_x = {{7{diff[8]}}, diff};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_q   <= '0;
            tgt_q   <= '0;
            err_v_q <= 1'b0;
            err_q   <= '0;
        end else begin
            if (res_fire) res_q <= bus.result_data;
            if (tgt_fire) tgt_q <= bus.target_data;
            if (err_load) begin
                err_v_q <= 1'b1;
                err_q   <= diff_x <<< SHIFT;
            end else if (err_fire) begin
                err_v_q <= 1'b0;
            end
        end
    end

`ifdef STEP_ERROR_COUNT_EN
    logic [COUNT_W-1:0] smp_q, mis_q;
    logic               mis_hit;

    assign mis_hit = tgt_fire && (bus.target_data != res_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            smp_q <= '0;
            mis_q <= '0;
        end else begin
            if (res_fire && (smp_q != '1)) smp_q <= smp_q + COUNT_W'(1);
            if (mis_hit && (mis_q != '1))  mis_q <= mis_q + COUNT_W'(1);
        end
    end

    assign sample_count   = smp_q;
    assign mismatch_count = mis_q;
`else
    assign sample_count   = '0;
    assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_step_error.sv
// Self-checking bench for step_error: vector table, corner
// sequences and randomized samples against a transaction model.
module tb_step_error;

    localparam int SHIFT = 4;
    localparam int CW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] mismatch_count;

    int total = 0;
    int bad   = 0;
    int n_smp = 0;
    int n_mis = 0;

    step_error_if bus();

    step_error #(.SHIFT(SHIFT), .COUNT_W(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus.slave),
        .sample_count   (sample_count),
        .mismatch_count (mismatch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        train;
        logic [7:0]  r;
        logic [7:0]  t;
        logic [15:0] err;
        int          dly;
    } vec_t;

    vec_t vecs [6];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] ref_err(logic [7:0] r, logic [7:0] t);
        int d;
        d = (int'(t) - int'(r)) * (1 << SHIFT);
        return d[15:0];
    endfunction

    function automatic int exp_cnt(int n);
`ifdef STEP_ERROR_COUNT_EN
        return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
`else
        return 0;
`endif
    endfunction

    task automatic check_counts(string tag);
        check({tag, "_smp"}, 32'(sample_count), 32'(exp_cnt(n_smp)));
        check({tag, "_mis"}, 32'(mismatch_count), 32'(exp_cnt(n_mis)));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.result_valid = 1'b0;
        bus.target_valid = 1'b0;
        bus.error_ready  = 1'b0;
        n_smp = 0;
        n_mis = 0;
        #2;
        check("rst_ev", 32'(bus.error_valid), 0);
        check("rst_ed", 32'(bus.error_data), 0);
        check("rst_rr", 32'(bus.result_ready), 1);
        check("rst_tr", 32'(bus.target_ready), 0);
        check_counts("rst");
        step();
        reset = 1'b1;
    endtask

    task automatic send(logic tr, logic [7:0] r, logic [7:0] t,
                        logic [15:0] exp, int dly);
        int k;
        bus.train        = tr;
        bus.result_data  = r;
        bus.result_valid = 1'b1;
        k = 0;
        while (!bus.result_ready && k < 20) begin
            step();
            k++;
        end
        check("res_rdy_wait", 32'(bus.result_ready), 1);
        step();
        bus.result_valid = 1'b0;
        bus.train = 1'($urandom);
        n_smp++;
        if (!tr) begin
            check("idle_rr", 32'(bus.result_ready), 1);
            check("idle_tr", 32'(bus.target_ready), 0);
            check("idle_ev", 32'(bus.error_valid), 0);
            check_counts("idle");
            return;
        end
        check("tgt_tr", 32'(bus.target_ready), 1);
        check("tgt_rr", 32'(bus.result_ready), 0);
        bus.target_data  = t;
        bus.target_valid = 1'b1;
        step();
        bus.target_valid = 1'b0;
        if (t != r) n_mis++;
        check("lat_ev0", 32'(bus.error_valid), 0);
        check("err_tr", 32'(bus.target_ready), 0);
        step();
        check("err_ev", 32'(bus.error_valid), 1);
        check("err_ed", 32'(bus.error_data), 32'(exp));
        for (int i = 0; i < dly; i++) begin
            step();
            check("bp_ev", 32'(bus.error_valid), 1);
            check("bp_ed", 32'(bus.error_data), 32'(exp));
            check("bp_rdys", 32'({bus.result_ready, bus.target_ready}), 0);
        end
        bus.error_ready = 1'b1;
        step();
        bus.error_ready = 1'b0;
        check("done_ev", 32'(bus.error_valid), 0);
        check("done_rr", 32'(bus.result_ready), 1);
        check("hold_ed", 32'(bus.error_data), 32'(exp));
        check_counts("done");
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hff, 8'h00, 16'hF010, 0};
        vecs[1] = '{1'b1, 8'h00, 8'hff, 16'h0FF0, 0};
        vecs[2] = '{1'b1, 8'hff, 8'hff, 16'h0000, 0};
        vecs[3] = '{1'b1, 8'h12, 8'h34, 16'h0220, 5};
        vecs[4] = '{1'b0, 8'h55, 8'haa, 16'h0000, 0};
        vecs[5] = '{1'b1, 8'h80, 8'h7f, 16'hFFF0, 1};

        bus.train        = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_data  = '0;
        bus.target_valid = 1'b0;
        bus.target_data  = '0;
        bus.error_ready  = 1'b0;

        do_reset();
        for (int i = 0; i < 6; i++)
            send(vecs[i].train, vecs[i].r, vecs[i].t, vecs[i].err, vecs[i].dly);

        // back-to-back non-training results
        do_reset();
        bus.train        = 1'b0;
        bus.result_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.result_data = 8'(i);
            check("b2b_rr", 32'(bus.result_ready), 1);
            check("b2b_tr_ev", 32'({bus.target_ready, bus.error_valid}), 0);
            step();
            n_smp++;
        end
        bus.result_valid = 1'b0;
        check_counts("b2b");

        // reset while an error is pending
        send(1'b1, 8'h01, 8'h03, ref_err(8'h01, 8'h03), 0);
        bus.train        = 1'b1;
        bus.result_data  = 8'hff;
        bus.result_valid = 1'b1;
        step();
        bus.result_valid = 1'b0;
        bus.target_data  = 8'h00;
        bus.target_valid = 1'b1;
        step();
        bus.target_valid = 1'b0;
        step();
        check("pre_rst_ev", 32'(bus.error_valid), 1);
        #2;
        reset = 1'b0;
        n_smp = 0;
        n_mis = 0;
        #1;
        check("async_ev", 32'(bus.error_valid), 0);
        check("async_rr", 32'(bus.result_ready), 1);
        check_counts("async");
        step();
        reset = 1'b1;
        step();
        check("post_rr", 32'(bus.result_ready), 1);
        check("post_ev", 32'(bus.error_valid), 0);

        // randomized samples against the model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic       tr;
            logic [7:0] r, t;
            tr = 1'($urandom_range(0, 1));
            r  = 8'($urandom);
            t  = ($urandom_range(0, 3) == 0) ? r : 8'($urandom);
            send(tr, r, t, ref_err(r, t), $urandom_range(0, 3));
        end

        // counter saturation
        do_reset();
        for (int i = 0; i < 20; i++)
            send(1'b1, 8'hff, 8'(i), ref_err(8'hff, 8'(i)), 0);
        check_counts("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_error.md
Name: step_error

Overview:
- Downstream partner of the step (Heaviside) activation unit. Consumes its 8-bit result stream and a matching 8-bit target stream.
- In training mode, returns a signed 16-bit error on the error stream, which feeds the activation unit's error input.
- Sits between the activation output and the training-data source. Acts as the delta-rule error generator for a single perceptron.

Parameters:
SHIFT, 4, left shift applied to the 9-bit signed difference; legal range 0..7
COUNT_W, 16, width of the sample and mismatch counters

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
train  input  1  training mode; sampled on the result handshake
result_valid  input  1  activation result valid
result_data  input  8  activation result (0x00 or 0xff nominal; any value accepted)
result_ready  output  1  result accepted
target_valid  input  1  target valid
target_data  input  8  desired output
target_ready  output  1  target accepted
error_valid  output  1  error valid
error_data  output  16  signed error, (target - result) << SHIFT
error_ready  input  1  error accepted downstream
sample_count  output  COUNT_W  results consumed, saturating
mismatch_count  output  COUNT_W  training samples with target != result, saturating

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous and active-low; asserting it forces the reset state immediately, independent of `clock`.
- Reset values:
  - state = RES
  - error_valid = 0, error_data = 0x0000
  - sample_count = 0, mismatch_count = 0
  - result and target capture registers = 0
- States: RES, TGT, ERR.
- RES:
  - result_ready = 1; all other readys low.
  - On result_valid & result_ready: capture result_data, sample train, increment sample_count.
  - Next state is TGT if train was 1, else RES.
  - With train low, back-to-back results are accepted every cycle.
- TGT:
  - target_ready = 1.
  - On handshake: capture target_data; state <= ERR.
- ERR:
  - On the first clock edge in ERR with error_valid = 0: error_valid <= 1 and error_data <= sign_extend_16((target - result) << SHIFT).
  - The 9-bit signed difference has range -255..255, so there is no overflow for SHIFT <= 7.
  - On error_valid & error_ready: error_valid <= 0 and state <= RES on the same edge.
  - error_data holds its value after the handshake until the next computation.
- Latency: error_valid rises exactly 1 cycle after the target handshake edge. Minimum training round trip is 3 edges (result, target, error) when all peers are always ready/valid.
- Backpressure:
  - With error_ready low, error_valid and error_data stay stable indefinitely.
  - result_ready and target_ready stay low throughout ERR.
- Only one readiness output (result_ready or target_ready) is high in any cycle; neither is high in ERR.
- train changes mid-sample have no effect until the next result handshake.
- Counters saturate at all-ones and do not wrap.
- mismatch_count increments on the target handshake when target_data != captured result.
- Reset mid-operation: any captured sample is discarded, counters clear, and no partial error is emitted.

Optional Feature:
STEP_ERROR_COUNT_EN
- Defined: sample_count and mismatch_count are implemented as specified above.
- Undefined: both ports are tied to 0, and no counter flops are synthesised.
- FSM and datapath are identical in both builds.

Test Plan:
- SHIFT=4, train=1, result 0xff, target 0x00, error_ready=1 -> error_data = 0xF010 (-4080); mismatch_count = 1; error_valid high exactly one cycle.
- train=1, result 0x00, target 0xff -> error_data = 0x0FF0. Then result 0xff, target 0xff -> error_data = 0x0000; mismatch_count unchanged.
- train=0, 10 results on consecutive cycles -> result_ready held high; target_ready and error_valid never assert; sample_count = 10.
- train=1, error_ready held low 5 cycles after error_valid rises -> error_valid and error_data stable; result_ready and target_ready low; handshake on cycle 6; result_ready high the next cycle.
- Assert reset during ERR with error_valid = 1 -> error_valid drops immediately (asynchronously); after release state is RES, result_ready = 1, counters = 0.
- Counters preloaded near saturation with STEP_ERROR_COUNT_EN defined (COUNT_W=4, 20 mismatching samples) -> both counters stick at 0xF. Same run without the macro -> counters read 0 and error values are identical.
